// File: rtl/tx_cmd_arbiter_if.sv
// Requester, transmitter and status signals of the two-requester command arbiter.
// slave = arbiter side, master = requester/transmitter side.
interface tx_cmd_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_action;
  logic       req0_row;
  logic [1:0] req0_col;
  logic [7:0] req0_data;

  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_action;
  logic       req1_row;
  logic [1:0] req1_col;
  logic [7:0] req1_data;

  logic [7:0] t_d;
  logic       t_row;
  logic [1:0] t_col;
  logic [2:0] t_action;
  logic       t_busy;

  logic       done;
  logic       done_id;
  logic       err;

  modport slave (
    input  req0_valid, req0_action, req0_row, req0_col, req0_data,
    input  req1_valid, req1_action, req1_row, req1_col, req1_data,
    input  t_busy,
    output req0_ready, req1_ready,
    output t_d, t_row, t_col, t_action,
    output done, done_id, err
  );

  modport master (
    output req0_valid, req0_action, req0_row, req0_col, req0_data,
    output req1_valid, req1_action, req1_row, req1_col, req1_data,
    output t_busy,
    input  req0_ready, req1_ready,
    input  t_d, t_row, t_col, t_action,
    input  done, done_id, err
  );
endinterface

// File: rtl/tx_cmd_arbiter.sv
// Round-robin arbiter sharing the cell-matrix UART transmitter between two requesters.
// Issues one-cycle action pulses and tracks t_busy so nothing is issued mid-frame.
module tx_cmd_arbiter #(
  parameter int unsigned BUSY_TO = 16,
  parameter int unsigned GAP     = 0
) (
  input  logic            clk,
  input  logic            rst,
  tx_cmd_arbiter_if.slave bus
);

  localparam int unsigned CMAX = (BUSY_TO > GAP) ? BUSY_TO : GAP;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          ptr, ptr_next;
  logic          owner, owner_next;
  logic [7:0]    d_q, d_next;
  logic          row_q, row_next;
  logic [1:0]    col_q, col_next;
  logic [2:0]    act_q, act_next;
  logic          done_q, done_next;
  logic          done_id_q, done_id_next;
  logic          err_q, err_next;

  logic          grant;
  logic          idle_free;
  logic          accept;
  logic          sel_valid;
  logic [2:0]    sel_action;
  logic          sel_row;
  logic [1:0]    sel_col;
  logic [7:0]    sel_data;
  logic          sel_legal;

  // A lone valid requester wins outright; with both valid the pointer decides.
  always_comb begin
    grant = ptr;
    if (bus.req0_valid && !bus.req1_valid) begin
      grant = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      grant = 1'b1;
    end
  end

  assign idle_free      = (state == S_IDLE) && !bus.t_busy;
  assign bus.req0_ready = idle_free && !grant;
  assign bus.req1_ready = idle_free && grant;

  assign sel_valid  = grant ? bus.req1_valid  : bus.req0_valid;
  assign sel_action = grant ? bus.req1_action : bus.req0_action;
  assign sel_row    = grant ? bus.req1_row    : bus.req0_row;
  assign sel_col    = grant ? bus.req1_col    : bus.req0_col;
  assign sel_data   = grant ? bus.req1_data   : bus.req0_data;
  assign sel_legal  = (sel_action >= 3'd1) && (sel_action <= 3'd5);
  assign accept     = idle_free && sel_valid;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    ptr_next     = ptr;
    owner_next   = owner;
    d_next       = d_q;
    row_next     = row_q;
    col_next     = col_q;
    act_next     = '0;
    done_next    = 1'b0;
    done_id_next = done_id_q;
    err_next     = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          ptr_next   = ~grant;
          owner_next = grant;
          if (sel_legal) begin
            d_next     = sel_data;
            row_next   = sel_row;
            col_next   = sel_col;
            act_next   = sel_action;
            state_next = S_ISSUE;
          end else begin
            err_next     = 1'b1;
            done_next    = 1'b1;
            done_id_next = grant;
          end
        end
      end

      S_ISSUE: begin
        cnt_next = '0;
        if (act_q == 3'd1) begin
          done_next    = 1'b1;
          done_id_next = owner;
          state_next   = (GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          state_next = S_WAIT_BUSY;
        end
      end

      // cnt counts WAIT_BUSY cycles already spent; timeout after BUSY_TO of them.
      S_WAIT_BUSY: begin
        if (bus.t_busy) begin
          state_next = S_WAIT_DONE;
        end else if (cnt == CW'(BUSY_TO - 1)) begin
          err_next     = 1'b1;
          done_next    = 1'b1;
          done_id_next = owner;
          state_next   = S_IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      S_WAIT_DONE: begin
        if (!bus.t_busy) begin
          cnt_next     = '0;
          done_next    = 1'b1;
          done_id_next = owner;
          state_next   = (GAP == 0) ? S_IDLE : S_GAP;
        end
      end

      S_GAP: begin
        if (cnt == CW'(GAP - 1)) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      d_q       <= '0;
      row_q     <= 1'b0;
      col_q     <= '0;
      act_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      ptr       <= ptr_next;
      owner     <= owner_next;
      d_q       <= d_next;
      row_q     <= row_next;
      col_q     <= col_next;
      act_q     <= act_next;
      done_q    <= done_next;
      done_id_q <= done_id_next;
      err_q     <= err_next;
    end
  end

  assign bus.t_d      = d_q;
  assign bus.t_row    = row_q;
  assign bus.t_col    = col_q;
  assign bus.t_action = act_q;
  assign bus.done     = done_q;
  assign bus.done_id  = done_id_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_tx_cmd_arbiter.sv
// Directed bench for tx_cmd_arbiter with a transmitter model whose busy length is
// set per test (0 = never goes busy).
module tb_tx_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned busy_len = 0;
  int unsigned bcnt = 0;

  tx_cmd_arbiter_if bus();

  tx_cmd_arbiter #(.BUSY_TO(16), .GAP(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [2:0] a,
                         input logic r, input logic [1:0] c, input logic [7:0] d);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_action = a; bus.req0_row = r;
      bus.req0_col = c; bus.req0_data = d;
    end else begin
      bus.req1_valid = v; bus.req1_action = a; bus.req1_row = r;
      bus.req1_col = c; bus.req1_data = d;
    end
  endtask

  // Transmitter model: goes busy for busy_len cycles after seeing a send action.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.t_busy <= 1'b0;
      bcnt       <= 0;
    end else if ((bus.t_action >= 3'd2) && (bus.t_action <= 3'd5) && (busy_len != 0)) begin
      bus.t_busy <= 1'b1;
      bcnt       <= busy_len;
    end else if (bus.t_busy) begin
      if (bcnt <= 1) bus.t_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (bus.t_busy) chk("act_while_busy", {29'd0, bus.t_action}, 32'd0);
      chk("ready_excl", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int ng;
    int issues;
    int gseq [4];

    set_req(0, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0);
    set_req(1, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0);
    repeat (3) @(negedge clk);
    chk("rst_t_d", {24'd0, bus.t_d}, 32'h0);
    chk("rst_t_action", {29'd0, bus.t_action}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);

    // 1: write from req0
    set_req(0, 1'b1, 3'd1, 1'b1, 2'd2, 8'hA5);
    #1 chk("t1_ready0", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    set_req(0, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0);
    chk("t1_action", {29'd0, bus.t_action}, 32'd1);
    chk("t1_d", {24'd0, bus.t_d}, 32'hA5);
    chk("t1_row", {31'd0, bus.t_row}, 32'd1);
    chk("t1_col", {30'd0, bus.t_col}, 32'd2);
    chk("t1_done_early", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    chk("t1_action_off", {29'd0, bus.t_action}, 32'd0);
    chk("t1_done", {31'd0, bus.done}, 32'd1);
    chk("t1_done_id", {31'd0, bus.done_id}, 32'd0);
    chk("t1_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", {31'd0, bus.done}, 32'd0);

    // 2: send-all with 300-cycle busy
    busy_len = 300;
    set_req(0, 1'b1, 3'd5, 1'b0, 2'd1, 8'h11);
    #1 chk("t2_ready0", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    set_req(0, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0);
    chk("t2_action", {29'd0, bus.t_action}, 32'd5);
    issues = 0;
    k = 0;
    while (k < 400 && !bus.done) begin
      @(negedge clk);
      k++;
      if (bus.t_action != 3'd0) issues++;
    end
    chk("t2_done_latency", k, 302);
    chk("t2_reissue", issues, 0);
    chk("t2_done_id", {31'd0, bus.done_id}, 32'd0);
    chk("t2_err", {31'd0, bus.err}, 32'd0);

    // 4: illegal code from req1
    set_req(1, 1'b1, 3'd7, 1'b1, 2'd3, 8'hFF);
    #1 chk("t4_ready1", {31'd0, bus.req1_ready}, 32'd1);
    chk("t4_ready0", {31'd0, bus.req0_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    set_req(1, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0);
    chk("t4_err", {31'd0, bus.err}, 32'd1);
    chk("t4_done", {31'd0, bus.done}, 32'd1);
    chk("t4_done_id", {31'd0, bus.done_id}, 32'd1);
    chk("t4_action", {29'd0, bus.t_action}, 32'd0);
    @(negedge clk);
    chk("t4_err_pulse", {31'd0, bus.err}, 32'd0);
    chk("t4_action2", {29'd0, bus.t_action}, 32'd0);

    // 3: both requesters contend, grants must alternate 0,1,0,1
    busy_len = 3;
    set_req(0, 1'b1, 3'd2, 1'b0, 2'd0, 8'h01);
    set_req(1, 1'b1, 3'd3, 1'b1, 2'd3, 8'h02);
    ng = 0;
    for (int cyc = 0; cyc < 200 && ng < 4; cyc++) begin
      #1;
      if (bus.req0_valid && bus.req0_ready) begin
        gseq[ng] = 0; ng++;
      end else if (bus.req1_valid && bus.req1_ready) begin
        gseq[ng] = 1; ng++;
      end
      if (bus.t_busy) begin
        chk("t3_ready0_busy", {31'd0, bus.req0_ready}, 32'd0);
        chk("t3_ready1_busy", {31'd0, bus.req1_ready}, 32'd0);
      end
      @(negedge clk);
    end
    set_req(0, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0);
    set_req(1, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0);
    chk("t3_grants", ng, 4);
    for (int i = 0; i < 4; i++) chk("t3_order", gseq[i], i % 2);
    k = 0;
    while (k < 50 && !bus.done) begin
      @(negedge clk);
      k++;
    end
    chk("t3_last_done", {31'd0, bus.done}, 32'd1);
    chk("t3_last_id", {31'd0, bus.done_id}, 32'd1);

    // 5: busy never rises -> timeout 16 cycles after WAIT_BUSY entry
    busy_len = 0;
    @(negedge clk);
    set_req(0, 1'b1, 3'd2, 1'b1, 2'd0, 8'h5A);
    #1 chk("t5_ready0", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    set_req(0, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0);
    chk("t5_action", {29'd0, bus.t_action}, 32'd2);
    k = 0;
    while (k < 40 && !bus.err) begin
      @(negedge clk);
      k++;
    end
    chk("t5_timeout_cycle", k, 17);
    chk("t5_done", {31'd0, bus.done}, 32'd1);
    chk("t5_done_id", {31'd0, bus.done_id}, 32'd0);
    @(negedge clk);
    chk("t5_err_pulse", {31'd0, bus.err}, 32'd0);
    set_req(1, 1'b1, 3'd1, 1'b0, 2'd3, 8'hC3);
    #1 chk("t5_next_ready1", {31'd0, bus.req1_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    set_req(1, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0);
    chk("t5_next_action", {29'd0, bus.t_action}, 32'd1);
    chk("t5_next_d", {24'd0, bus.t_d}, 32'hC3);
    @(negedge clk);
    chk("t5_next_done_id", {31'd0, bus.done_id}, 32'd1);

    // 6: async reset while in WAIT_DONE
    busy_len = 300;
    set_req(0, 1'b1, 3'd3, 1'b1, 2'd1, 8'h3C);
    #1 chk("t6_ready0", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    set_req(0, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0);
    chk("t6_d", {24'd0, bus.t_d}, 32'h3C);
    repeat (5) @(negedge clk);
    chk("t6_busy", {31'd0, bus.t_busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_d", {24'd0, bus.t_d}, 32'd0);
    chk("t6_rst_row", {31'd0, bus.t_row}, 32'd0);
    chk("t6_rst_col", {30'd0, bus.t_col}, 32'd0);
    chk("t6_rst_action", {29'd0, bus.t_action}, 32'd0);
    chk("t6_rst_done", {31'd0, bus.done}, 32'd0);
    chk("t6_rst_done_id", {31'd0, bus.done_id}, 32'd0);
    chk("t6_rst_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b1, 3'd4, 1'b0, 2'd2, 8'h77);
    set_req(1, 1'b1, 3'd2, 1'b1, 2'd1, 8'h88);
    #1 chk("t6_first_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("t6_first_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    set_req(0, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0);
    set_req(1, 1'b0, 3'd0, 1'b0, 2'd0, 8'd0);
    chk("t6_first_action", {29'd0, bus.t_action}, 32'd4);
    chk("t6_first_d", {24'd0, bus.t_d}, 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
